// File: rtl/ex_stage_pkg.sv
// Shared types, widths and decode constants
// for the MIPS execute stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int S1_RS   = 0;
  localparam int S1_PC   = 1;
  localparam int S1_SA   = 2;
  localparam int S2_RT   = 0;
  localparam int S2_SIMM = 1;
  localparam int S2_8    = 2;
  localparam int S2_ZIMM = 3;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  // One restoring step: returns {rem, quot}.
  function automatic logic [63:0] div_step(
    input logic [31:0] r,
    input logic [31:0] q,
    input logic [31:0] d
  );
    logic [32:0] t;
    logic        ge;
    t  = {r, q[31]};
    ge = (t >= {1'b0, d});
    if (ge) t = t - {1'b0, d};
    return {t[31:0], q[30:0], ge};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode/execute/memory bus bundle around
// the execute stage.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id_bus,
    input  data_sram_en, data_sram_wen,
    input  data_sram_addr, data_sram_wdata,
    input  stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id_bus,
    output data_sram_en, data_sram_wen,
    output data_sram_addr, data_sram_wdata,
    output stallreq_for_ex
  );

endinterface

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: 32 steps,
// then a single-cycle DONE with sign fixup.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, a_q;
  logic        neg_q, neg_r, dz_q;
  logic [31:0] a_abs, b_abs;

  assign a_abs = (is_signed && a[31]) ? -a : a;
  assign b_abs = (is_signed && b[31]) ? -b : b;

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (start) state_d = DIV_RUN;
      DIV_RUN:  if (cnt_q == 5'd31) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != DIV_IDLE);
    done = (state_q == DIV_DONE);
  end

  // First step is taken on the start edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_q  <= 1'b0;
    end else if (state_q == DIV_IDLE && start) begin
      {rem_q, quo_q} <= div_step('0, a_abs, b_abs);
      cnt_q <= 5'd1;
      dvs_q <= b_abs;
      a_q   <= a;
      neg_q <= is_signed & (a[31] ^ b[31]);
      neg_r <= is_signed & a[31];
      dz_q  <= (b == '0);
    end else if (state_q == DIV_RUN) begin
      {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
      cnt_q <= cnt_q + 5'd1;
    end
  end

  always_comb begin
    quot = neg_q ? -quo_q : quo_q;
    rem  = neg_r ? -rem_q : rem_q;
    if (dz_q) begin
      quot = '1;
      rem  = a_q;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, ALU,
// HI/LO, multiply and iterative divide.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ex_stage_if.slave bus
);

  id_ex_t      r_q;
  logic        load_new, bubble;
  logic [31:0] src1, src2, alu, result;
  logic [31:0] hi_q, lo_q;
  logic [31:0] simm, zimm;
  logic [5:0]  func;
  logic        spec;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic        is_mult, is_multu, is_divs, is_divu;
  logic        is_div, div_fin_q, start;
  logic        div_busy, div_done;
  logic [31:0] div_quot, div_rem;
  logic [63:0] prod_s, prod_u;
  logic        unused_inst;

  assign load_new = (bus.stall[2] == NO_STOP);
  assign bubble   = (bus.stall[2] == STOP) &&
                    (bus.stall[3] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst)           r_q <= '0;
    else if (bubble)   r_q <= '0;
    else if (load_new) r_q <= id_ex_t'(bus.id_to_ex_bus);
  end

  assign simm = {{16{r_q.inst[15]}}, r_q.inst[15:0]};
  assign zimm = {16'h0, r_q.inst[15:0]};
  assign unused_inst = ^r_q.inst[25:16];

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      r_q.sel_src1[S1_RS]: src1 = r_q.rdata1;
      r_q.sel_src1[S1_PC]: src1 = r_q.pc;
      r_q.sel_src1[S1_SA]: src1 = {27'h0, r_q.inst[10:6]};
      default:             src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      r_q.sel_src2[S2_RT]:   src2 = r_q.rdata2;
      r_q.sel_src2[S2_SIMM]: src2 = simm;
      r_q.sel_src2[S2_8]:    src2 = 32'd8;
      r_q.sel_src2[S2_ZIMM]: src2 = zimm;
      default:               src2 = '0;
    endcase
  end

  always_comb begin
    alu = '0;
    unique case (1'b1)
      r_q.alu_op[ALU_ADD]:  alu = src1 + src2;
      r_q.alu_op[ALU_SUB]:  alu = src1 - src2;
      r_q.alu_op[ALU_SLT]:
        alu = {31'h0, $signed(src1) < $signed(src2)};
      r_q.alu_op[ALU_SLTU]: alu = {31'h0, src1 < src2};
      r_q.alu_op[ALU_AND]:  alu = src1 & src2;
      r_q.alu_op[ALU_NOR]:  alu = ~(src1 | src2);
      r_q.alu_op[ALU_OR]:   alu = src1 | src2;
      r_q.alu_op[ALU_XOR]:  alu = src1 ^ src2;
      r_q.alu_op[ALU_SLL]:  alu = src2 << src1[4:0];
      r_q.alu_op[ALU_SRL]:  alu = src2 >> src1[4:0];
      r_q.alu_op[ALU_SRA]:
        alu = $unsigned($signed(src2) >>> src1[4:0]);
      r_q.alu_op[ALU_LUI]:  alu = {src2[15:0], 16'h0};
      default:              alu = '0;
    endcase
  end

  assign func     = r_q.inst[5:0];
  assign spec     = (r_q.inst[31:26] == 6'd0);
  assign is_mfhi  = spec && func == F_MFHI;
  assign is_mflo  = spec && func == F_MFLO;
  assign is_mthi  = spec && func == F_MTHI;
  assign is_mtlo  = spec && func == F_MTLO;
  assign is_mult  = spec && func == F_MULT;
  assign is_multu = spec && func == F_MULTU;
  assign is_divs  = spec && func == F_DIV;
  assign is_divu  = spec && func == F_DIVU;
  assign is_div   = is_divs | is_divu;

  assign prod_s = {{32{r_q.rdata1[31]}}, r_q.rdata1} *
                  {{32{r_q.rdata2[31]}}, r_q.rdata2};
  assign prod_u = {32'h0, r_q.rdata1} *
                  {32'h0, r_q.rdata2};

  // div_fin_q stops a held div from restarting.
  assign start = is_div & ~div_busy & ~div_fin_q;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_divs),
    .a         (r_q.rdata1),
    .b         (r_q.rdata2),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst)                    div_fin_q <= 1'b0;
    else if (bubble | load_new) div_fin_q <= 1'b0;
    else if (div_done)          div_fin_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_done) begin
      hi_q <= div_rem;
      lo_q <= div_quot;
    end else if (is_mult) begin
      {hi_q, lo_q} <= prod_s;
    end else if (is_multu) begin
      {hi_q, lo_q} <= prod_u;
    end else if (is_mthi) begin
      hi_q <= r_q.rdata1;
    end else if (is_mtlo) begin
      lo_q <= r_q.rdata1;
    end
  end

  assign result = is_mfhi ? hi_q :
                  is_mflo ? lo_q : alu;

  assign bus.ex_to_mem_bus = {
    r_q.pc, r_q.ram_en, r_q.ram_wen,
    r_q.sel_rf_res, r_q.rf_we,
    r_q.rf_waddr, result
  };
  assign bus.ex_to_id_bus =
    {r_q.rf_we, r_q.rf_waddr, result};

  assign bus.data_sram_en    = r_q.ram_en;
  assign bus.data_sram_wen   = r_q.ram_wen;
  assign bus.data_sram_addr  = alu;
  assign bus.data_sram_wdata = r_q.rdata2;
  assign bus.stallreq_for_ex =
    is_div & ~div_done & ~div_fin_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: ALU, stall,
// HI/LO, multiply and divider paths.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if bus();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int total    = 0;
  logic [75:0] exp_q[$];

  typedef struct {
    id_ex_t      x;
    logic [31:0] r;
  } vec_t;

  function automatic id_ex_t mk(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic [11:0] op,
    input logic [2:0]  s1,
    input logic [3:0]  s2,
    input logic        ren,
    input logic [3:0]  wen,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] a,
    input logic [31:0] b
  );
    id_ex_t x;
    x.pc = pc;
    x.inst = inst;
    x.alu_op = op;
    x.sel_src1 = s1;
    x.sel_src2 = s2;
    x.ram_en = ren;
    x.ram_wen = wen;
    x.rf_we = we;
    x.rf_waddr = wa;
    x.sel_rf_res = ren & ~|wen;
    x.rdata1 = a;
    x.rdata2 = b;
    return x;
  endfunction

  function automatic id_ex_t sp(
    input logic [5:0]  f,
    input logic        we,
    input logic [31:0] a,
    input logic [31:0] b
  );
    return mk(32'h2000,
      {6'h0, 5'd1, 5'd2, 5'd4, 5'd0, f},
      12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
      we, 5'd4, a, b);
  endfunction

  function automatic logic [75:0] em(
    input id_ex_t x,
    input logic [31:0] res
  );
    return {x.pc, x.ram_en, x.ram_wen,
            x.sel_rf_res, x.rf_we,
            x.rf_waddr, res};
  endfunction

  task automatic drive(
    input id_ex_t x,
    input logic [5:0] st
  );
    bus.id_to_ex_bus = x;
    bus.stall = st;
    @(negedge clk);
  endtask

  // Issue x, then compare the next output
  // against the queued expectation.
  task automatic send(
    input string nm,
    input id_ex_t x,
    input logic [31:0] res
  );
    logic [75:0] e;
    exp_q.push_back(em(x, res));
    drive(x, 6'b0);
    e = exp_q.pop_front();
    total++;
    if (bus.ex_to_mem_bus !== e)
      $display("FAIL %s: got %h want %h",
               nm, bus.ex_to_mem_bus, e);
    else pass_cnt++;
  endtask

  task automatic run_div(
    input id_ex_t x,
    output int cnt
  );
    drive(x, 6'b0);
    cnt = 0;
    while (cnt < 100) begin
      if (!bus.stallreq_for_ex) break;
      cnt++;
      bus.stall = 6'b001111;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(mk(32'h10, 32'h0, 12'h800, 3'b1,
             4'b1, 1'b1, 4'hF, 1'b1, 5'd3,
             32'd1, 32'd2), 6'b0);
    drive(mk(32'h10, 32'h0, 12'h800, 3'b1,
             4'b1, 1'b1, 4'hF, 1'b1, 5'd3,
             32'd1, 32'd2), 6'b0);
    total++;
    if (bus.ex_to_mem_bus !== '0)
      $display("FAIL reset_mem: got %h want 0",
               bus.ex_to_mem_bus);
    else pass_cnt++;
    total++;
    if (bus.ex_to_id_bus !== '0)
      $display("FAIL reset_id: got %h want 0",
               bus.ex_to_id_bus);
    else pass_cnt++;
    total++;
    if (bus.data_sram_en !== 1'b0)
      $display("FAIL reset_en: got %b want 0",
               bus.data_sram_en);
    else pass_cnt++;
    total++;
    if (bus.stallreq_for_ex !== 1'b0)
      $display("FAIL reset_stallreq: got %b want 0",
               bus.stallreq_for_ex);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_ori;
    id_ex_t x;
    x = mk(32'h400, {6'h0d, 5'd1, 5'd2, 16'h8001},
           12'h020, 3'b001, 4'b1000, 1'b0, 4'h0,
           1'b1, 5'd2, 32'h0000_00F0, 32'h0);
    send("ori", x, 32'h0000_80F1);
    total++;
    if (bus.ex_to_id_bus !== {1'b1, 5'd2, 32'h80F1})
      $display("FAIL ori_fwd: got %h want %h",
               bus.ex_to_id_bus,
               {1'b1, 5'd2, 32'h80F1});
    else pass_cnt++;
  endtask

  task automatic test_alu;
    vec_t v[13];
    id_ex_t x;
    logic [31:0] gi, si, ri;
    gi = {6'h08, 5'd1, 5'd3, 16'hFFFC};
    si = {6'h0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h00};
    ri = {6'h0, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03};
    v[0] = '{mk(32'h500, gi, 12'h800, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'd5, 32'd7), 32'd12};
    v[1] = '{mk(32'h504, gi, 12'h400, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'd5, 32'd7), 32'hFFFF_FFFE};
    v[2] = '{mk(32'h508, gi, 12'h200, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'hFFFF_FFFF, 32'd1), 32'd1};
    v[3] = '{mk(32'h50C, gi, 12'h100, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'hFFFF_FFFF, 32'd1), 32'd0};
    v[4] = '{mk(32'h510, gi, 12'h080, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'hF0F0, 32'h0FF0), 32'h00F0};
    v[5] = '{mk(32'h514, gi, 12'h040, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'h0, 32'hF0), 32'hFFFF_FF0F};
    v[6] = '{mk(32'h518, gi, 12'h010, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'hAAAA, 32'hFFFF), 32'h5555};
    v[7] = '{mk(32'h51C, si, 12'h008, 3'b100, 4'b1,
      0, 0, 1, 5'd3, 32'h0, 32'h11), 32'h110};
    v[8] = '{mk(32'h520, gi, 12'h004, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'd8, 32'h8000_0000),
      32'h0080_0000};
    v[9] = '{mk(32'h524, ri, 12'h002, 3'b100, 4'b1,
      0, 0, 1, 5'd3, 32'h0, 32'h8000_0000),
      32'hF800_0000};
    v[10] = '{mk(32'h528, {16'h3C03, 16'h1234},
      12'h001, 3'b0, 4'b1000, 0, 0, 1, 5'd3,
      32'h0, 32'h0), 32'h1234_0000};
    v[11] = '{mk(32'h1000, gi, 12'h800, 3'b010,
      4'b0100, 0, 0, 1, 5'd31, 32'h0, 32'h0),
      32'h0000_1008};
    v[12] = '{mk(32'h530, gi, 12'h000, 3'b1, 4'b1,
      0, 0, 1, 5'd3, 32'd5, 32'd7), 32'h0};
    for (int i = 0; i < 13; i++)
      send($sformatf("alu%0d", i), v[i].x, v[i].r);
    x = mk(32'h600, gi, 12'h800, 3'b1, 4'b10,
           1'b1, 4'hF, 1'b0, 5'd0,
           32'h100, 32'hDEAD_BEEF);
    send("sw_bus", x, 32'h0000_00FC);
    total++;
    if (bus.data_sram_en !== 1'b1)
      $display("FAIL sw_en: got %b want 1",
               bus.data_sram_en);
    else pass_cnt++;
    total++;
    if (bus.data_sram_wen !== 4'hF)
      $display("FAIL sw_wen: got %h want F",
               bus.data_sram_wen);
    else pass_cnt++;
    total++;
    if (bus.data_sram_addr !== 32'hFC)
      $display("FAIL sw_addr: got %h want FC",
               bus.data_sram_addr);
    else pass_cnt++;
    total++;
    if (bus.data_sram_wdata !== 32'hDEAD_BEEF)
      $display("FAIL sw_wdata: got %h want DEADBEEF",
               bus.data_sram_wdata);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    id_ex_t x, y, z;
    logic [75:0] e;
    x = mk(32'h700, 32'h2000_0000, 12'h800, 3'b1,
           4'b1, 1'b1, 4'h3, 1'b1, 5'd9,
           32'd1, 32'd1);
    y = mk(32'h704, 32'h2000_0000, 12'h800, 3'b1,
           4'b1, 1'b0, 4'h0, 1'b1, 5'd8,
           32'd3, 32'd4);
    z = mk(32'h708, 32'h2000_0000, 12'h400, 3'b1,
           4'b1, 1'b0, 4'h0, 1'b1, 5'd7,
           32'd9, 32'd1);
    exp_q.push_back('0);
    drive(x, 6'b000100);
    e = exp_q.pop_front();
    total++;
    if (bus.ex_to_mem_bus !== e)
      $display("FAIL bubble_bus: got %h want %h",
               bus.ex_to_mem_bus, e);
    else pass_cnt++;
    total++;
    if (bus.data_sram_en !== 1'b0 ||
        bus.ex_to_id_bus[37] !== 1'b0)
      $display("FAIL bubble_en: got %b%b want 00",
               bus.data_sram_en, bus.ex_to_id_bus[37]);
    else pass_cnt++;
    send("stall_load", y, 32'd7);
    exp_q.push_back(em(y, 32'd7));
    drive(z, 6'b001100);
    e = exp_q.pop_front();
    total++;
    if (bus.ex_to_mem_bus !== e)
      $display("FAIL stall_hold: got %h want %h",
               bus.ex_to_mem_bus, e);
    else pass_cnt++;
    send("stall_release", z, 32'd8);
  endtask

  task automatic test_div;
    int cnt;
    run_div(sp(F_DIV, 1'b0, -32'sd7, 32'd2), cnt);
    total++;
    if (cnt !== 32)
      $display("FAIL div_stall_len: got %0d want 32",
               cnt);
    else pass_cnt++;
    send("div_lo", sp(F_MFLO, 1'b1, 0, 0),
         32'hFFFF_FFFD);
    send("div_hi", sp(F_MFHI, 1'b1, 0, 0),
         32'hFFFF_FFFF);
  endtask

  task automatic test_divu_zero;
    int cnt;
    run_div(sp(F_DIVU, 1'b0, 32'd5, 32'd0), cnt);
    total++;
    if (cnt + 1 !== 33)
      $display("FAIL dz_latency: got %0d want 33",
               cnt + 1);
    else pass_cnt++;
    send("dz_lo", sp(F_MFLO, 1'b1, 0, 0),
         32'hFFFF_FFFF);
    send("dz_hi", sp(F_MFHI, 1'b1, 0, 0), 32'd5);
  endtask

  task automatic test_rst_mid_div;
    int cnt;
    drive(sp(F_DIVU, 1'b0, 32'd50, 32'd3), 6'b0);
    for (int i = 0; i < 10; i++) begin
      bus.stall = 6'b001111;
      @(negedge clk);
    end
    rst = 1'b1;
    drive('0, 6'b0);
    rst = 1'b0;
    total++;
    if (bus.stallreq_for_ex !== 1'b0)
      $display("FAIL rst_stallreq: got %b want 0",
               bus.stallreq_for_ex);
    else pass_cnt++;
    send("rst_lo", sp(F_MFLO, 1'b1, 0, 0), 32'd0);
    send("rst_hi", sp(F_MFHI, 1'b1, 0, 0), 32'd0);
    run_div(sp(F_DIVU, 1'b0, 32'd100, 32'd7), cnt);
    total++;
    if (cnt !== 32)
      $display("FAIL rst_div_len: got %0d want 32",
               cnt);
    else pass_cnt++;
    send("divu_lo", sp(F_MFLO, 1'b1, 0, 0), 32'd14);
    send("divu_hi", sp(F_MFHI, 1'b1, 0, 0), 32'd2);
    for (int i = 0; i < 40; i++) @(negedge clk);
    send("no_stale_lo", sp(F_MFLO, 1'b1, 0, 0),
         32'd14);
  endtask

  task automatic test_mult;
    send("mult", sp(F_MULT, 1'b0,
         32'h8000_0000, 32'd2), 32'd0);
    send("mult_hi", sp(F_MFHI, 1'b1, 0, 0),
         32'hFFFF_FFFF);
    send("mult_lo", sp(F_MFLO, 1'b1, 0, 0), 32'd0);
    send("multu", sp(F_MULTU, 1'b0,
         32'h8000_0000, 32'd2), 32'd0);
    send("multu_hi", sp(F_MFHI, 1'b1, 0, 0), 32'd1);
    send("multu_lo", sp(F_MFLO, 1'b1, 0, 0), 32'd0);
    send("mthi", sp(F_MTHI, 1'b0,
         32'hCAFE, 0), 32'd0);
    send("mthi_rd", sp(F_MFHI, 1'b1, 0, 0),
         32'hCAFE);
    send("mtlo", sp(F_MTLO, 1'b0,
         32'hBEEF, 0), 32'd0);
    send("mtlo_rd", sp(F_MFLO, 1'b1, 0, 0),
         32'hBEEF);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = '0;
    bus.id_to_ex_bus = '0;
    @(negedge clk);
    test_reset();
    test_ori();
    test_alu();
    test_stall();
    test_div();
    test_divu_zero();
    test_rst_mid_div();
    test_mult();
    $display("%0d/%0d checks passed",
             pass_cnt, total);
    $finish;
  end

endmodule
